rob_commit_unit: RTL and testbench
==================================

// Module: rob_commit_unit
// PURPOSE
//  Retirement stage directly downstream of the reorder buffer.
//  - Watches the ROB head and pops it once the head is ready.
//  - Completed register-writing results go to the architectural register file.
//  - Stores are released to the store buffer through a req/ack handshake; the
//    store must be acknowledged before it retires.
//  - Keeps a count of retired instructions.
// PARAMETERS
//  CNT_W   32   width of the retired-instruction counter
// PORTS
//  clock         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low
//  halt          in   1   1 = no new commit may start
//  rob_empty     in   1   ROB is_empty
//  head_instr    in   32  ROB head instruction; 0 when empty
//  head_val      in   32  ROB head result value
//  head_ready    in   1   ROB head has finished
//  rob_pop       out  1   pop strobe to ROB; combinational
//  rf_we         out  1   register file write enable; registered
//  rf_waddr      out  5   register file write address; registered
//  rf_wdata      out  32  register file write data; registered
//  st_commit     out  1   store release request; registered
//  st_tag        out  32  instruction word of the store being released; registered
//  st_ack        in   1   store buffer accepted the release
//  retire_count  out  CNT_W  number of pops since reset; wraps
//  busy          out  1   1 while in ST_WAIT
// BEHAVIOUR
//  Reset (async, reset==0):
//  - State goes to IDLE.
//  - rf_we=0, rf_waddr=0, rf_wdata=0, st_commit=0, st_tag=0, retire_count=0.
//  - rob_pop is 0 while in reset.
//  - Reset asserted mid-ST_WAIT abandons the store: st_commit drops immediately
//    and no pop is issued.
//  Decode of head_instr:
//  - op = [31:27], rd = [26:22].
//  - Writes rd: op 00000 (ALU), 00101 (addi), 01000 (lw).
//  - jal (00011): writes r31. setx (10101): writes r30.
//  - Store: op 00111 (sw).
//  - No write: all other ops, including 00010, 00110, 00001, 00100 and nop (0).
//  - Any write with destination 0 is suppressed (rf_we stays 0). The pop still
//    happens.
//  Commit condition: cand = !rob_empty & head_ready & !halt.
//  FSM states: IDLE and ST_WAIT.
//  - IDLE, cand, non-store:
//    - rob_pop=1 in the same cycle.
//    - Next edge: rf_we=write?1:0, rf_waddr=dest, rf_wdata=head_val; retire_count+1.
//    - Stay in IDLE.
//    - Back-to-back commits: one per cycle.
//  - IDLE, cand, store:
//    - rob_pop=0.
//    - Next edge: st_commit=1, st_tag=head_instr; go to ST_WAIT.
//  - ST_WAIT:
//    - st_commit is held at 1 and halt is ignored.
//    - Cycle with st_ack=1: rob_pop=1.
//    - Next edge: st_commit=0, retire_count+1, go to IDLE.
//    - First possible next commit is the cycle after returning to IDLE, so a
//      store costs at least 2 cycles.
//  - Not cand in IDLE: rob_pop=0; rf_we=0 at the next edge.
//  - st_ack while in IDLE is ignored.
//  - rf_we is a single-cycle pulse per register-writing retirement.
//    rf_waddr/rf_wdata hold their last value while rf_we=0.
//  - rob_pop is never asserted when head_ready=0 or rob_empty=1. The ROB
//    ignores pops on an unready head; this block must not rely on that.
//  - retire_count wraps modulo 2^CNT_W.
//  - busy = (state==ST_WAIT).
// TESTING
//  1. Reset: hold reset low, drive ready ALU head -> rob_pop=0, all outputs 0.
//     Release reset -> pop on the first cycle.
//  2. Back-to-back: add r3 (val 0x11), then addi r4 (val 0x22), both ready ->
//     rob_pop high 2 cycles; rf_we pulses (3,0x11) then (4,0x22);
//     retire_count=2.
//  3. Store: sw head ready, st_ack returned 3 cycles later ->
//     - st_commit high for 3 cycles with st_tag=head_instr;
//     - rob_pop only in the ack cycle; rf_we stays 0; count+1.
//  4. Suppression: jal (val 0x40) -> write r31=0x40.
//     ALU with rd=0 -> pop, rf_we=0. Branch -> pop, rf_we=0.
//  5. Stall: head not ready for 4 cycles, then ready with halt=1 -> no pop.
//     halt=0 -> pop next cycle. halt raised in ST_WAIT -> store still completes.
//  6. Reset mid-store: assert reset in ST_WAIT -> st_commit=0 immediately;
//     no pop; IDLE after release. Counter wrap checked with CNT_W=3: 8 commits
//     -> 0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Retirement stage behind the reorder buffer: pops ready heads, writes results to the
// architectural register file, and releases stores to the store buffer via req/ack.
module rob_commit_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             halt_i,
    input  logic             rob_empty_i,
    input  logic [31:0]      head_instr_i,
    input  logic [31:0]      head_val_i,
    input  logic             head_ready_i,
    output logic             rob_pop_o,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic             st_commit_o,
    output logic [31:0]      st_tag_o,
    input  logic             st_ack_i,
    output logic [CNT_W-1:0] retire_count_o,
    output logic             busy_o
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_SW   = 5'b00111;

    state_e           state_q;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q;
    logic [31:0]      rf_wdata_q;
    logic             st_commit_q;
    logic [31:0]      st_tag_q;
    logic [CNT_W-1:0] cnt_q;

    logic [4:0] op, rd, dest;
    logic       writes, wr_en, is_store;
    logic       head_ok, cand, pop;

    assign op       = head_instr_i[31:27];
    assign rd       = head_instr_i[26:22];
    assign is_store = (op == OP_SW);

    always_comb begin
        writes = 1'b0;
        dest   = 5'd0;
        case (op)
            OP_ALU, OP_ADDI, OP_LW: begin writes = 1'b1; dest = rd;     end
            OP_JAL:                 begin writes = 1'b1; dest = 5'd31;  end
            OP_SETX:                begin writes = 1'b1; dest = 5'd30;  end
            default:                begin writes = 1'b0; dest = 5'd0;   end
        endcase
    end

    // r0 is never written, but the instruction still retires.
    assign wr_en   = writes && (dest != 5'd0);
    assign head_ok = !rob_empty_i && head_ready_i;
    assign cand    = head_ok && !halt_i;

    // The ROB may hand us an unready head; never pop one, even on a store ack.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_IDLE: pop = cand && !is_store;
            ST_WAIT: pop = st_ack_i && head_ok;
            default: pop = 1'b0;
        endcase
    end

    assign rob_pop_o = rst_ni && pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
            st_commit_q <= 1'b0;
            st_tag_q    <= 32'd0;
            cnt_q       <= '0;
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cand) begin
                        if (is_store) begin
                            st_commit_q <= 1'b1;
                            st_tag_q    <= head_instr_i;
                            state_q     <= ST_WAIT;
                        end else begin
                            rf_we_q <= wr_en;
                            if (wr_en) begin
                                rf_waddr_q <= dest;
                                rf_wdata_q <= head_val_i;
                            end
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // Halt is deliberately ignored here: the store is already in flight.
                    if (pop) begin
                        st_commit_q <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign st_commit_o    = st_commit_q;
    assign st_tag_o       = st_tag_q;
    assign retire_count_o = cnt_q;
    assign busy_o         = (state_q == ST_WAIT);

endmodule

// File: tb/tb_rob_commit_unit.sv
// Scoreboard bench for rob_commit_unit: expected register writes are queued when a
// commit is driven and matched when rf_we appears; a 3-bit-counter copy checks wrap.
module tb_rob_commit_unit;

    logic        clk = 1'b0;
    logic        rst_n, halt, rob_empty, head_ready, st_ack;
    logic [31:0] head_instr, head_val;

    logic        rob_pop, rf_we, st_commit, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, st_tag;
    logic [31:0] retire_count;

    logic        rob_pop3, rf_we3, st_commit3, busy3;
    logic [4:0]  rf_waddr3;
    logic [31:0] rf_wdata3, st_tag3;
    logic [2:0]  retire_count3;

    always #5 clk = ~clk;

    rob_commit_unit #(.CNT_W(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .rob_empty_i(rob_empty),
        .head_instr_i(head_instr), .head_val_i(head_val), .head_ready_i(head_ready),
        .rob_pop_o(rob_pop), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .st_commit_o(st_commit), .st_tag_o(st_tag), .st_ack_i(st_ack),
        .retire_count_o(retire_count), .busy_o(busy)
    );

    rob_commit_unit #(.CNT_W(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .rob_empty_i(rob_empty),
        .head_instr_i(head_instr), .head_val_i(head_val), .head_ready_i(head_ready),
        .rob_pop_o(rob_pop3), .rf_we_o(rf_we3), .rf_waddr_o(rf_waddr3), .rf_wdata_o(rf_wdata3),
        .st_commit_o(st_commit3), .st_tag_o(st_tag3), .st_ack_i(st_ack),
        .retire_count_o(retire_count3), .busy_o(busy3)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;
    int  exp_ret = 0;

    localparam logic [4:0] OP_ALU = 5'b00000, OP_ADDI = 5'b00101, OP_LW = 5'b01000;
    localparam logic [4:0] OP_JAL = 5'b00011, OP_SETX = 5'b10101, OP_SW = 5'b00111;
    localparam logic [4:0] OP_BR  = 5'b00010;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h15A5A};
    endfunction

    task automatic head(input logic e, input logic [31:0] ins, input logic [31:0] val,
                        input logic rdy);
        rob_empty  = e;
        head_instr = ins;
        head_val   = val;
        head_ready = rdy;
    endtask

    // One clock: check the combinational pop and store state mid-cycle, then step past the edge.
    task automatic cyc(input logic ep, input logic ew, input string tag);
        @(negedge clk);
        chk({tag, "_pop"}, rob_pop, ep);
        chk({tag, "_pop3"}, rob_pop3, ep);
        chk({tag, "_stc"}, st_commit, ew);
        chk({tag, "_busy"}, busy, ew);
        if (ep) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_chk(input string tag);
        chk(tag, retire_count, exp_ret);
        chk({tag, "_w3"}, retire_count3, exp_ret & 7);
    endtask

    task automatic commit(input logic [31:0] ins, input logic [31:0] val,
                          input logic we, input logic [4:0] addr);
        wr_t e;
        head(1'b0, ins, val, 1'b1);
        if (we) begin
            e.a = addr;
            e.d = val;
            sb.push_back(e);
        end
        cyc(1'b1, 1'b0, "commit");
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we) begin
            if (sb.size() == 0) chk("rf_we_spurious", 1, 0);
            else begin
                e = sb.pop_front();
                chk("rf_waddr", rf_waddr, e.a);
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    initial begin
        logic [31:0] sw;
        wr_t e;
        sw     = mk(OP_SW, 5'd5);
        rst_n  = 1'b0;
        halt   = 1'b0;
        st_ack = 1'b0;
        head(1'b0, mk(OP_ALU, 5'd3), 32'h11, 1'b1);

        // Reset holds everything quiet even with a ready head.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pop", rob_pop, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_stc", st_commit, 0);
        chk("rst_tag", st_tag, 0);
        chk("rst_cnt", retire_count, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back commits right out of reset.
        e.a = 5'd3; e.d = 32'h11; sb.push_back(e);
        cyc(1'b1, 1'b0, "rst_rel");
        commit(mk(OP_ADDI, 5'd4), 32'h22, 1'b1, 5'd4);
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "b2b_idle");
        cnt_chk("b2b_cnt");
        chk("hold_we", rf_we, 0);
        chk("hold_addr", rf_waddr, 4);
        chk("hold_data", rf_wdata, 32'h22);

        // Store acked on the third waiting cycle.
        head(1'b0, sw, 32'h99, 1'b1);
        cyc(1'b0, 1'b0, "st_req");
        chk("st_tag", st_tag, sw);
        cyc(1'b0, 1'b1, "st_w1");
        cyc(1'b0, 1'b1, "st_w2");
        st_ack = 1'b1;
        cyc(1'b1, 1'b1, "st_ack");
        st_ack = 1'b0;
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "st_done");
        cnt_chk("st_cnt");

        // Ack while idle is ignored; halt blocks the store request.
        head(1'b0, sw, 32'h0, 1'b1);
        halt = 1'b1; st_ack = 1'b1;
        cyc(1'b0, 1'b0, "ack_idle");
        halt = 1'b0; st_ack = 1'b0;

        // Decode and r0 suppression.
        commit(mk(OP_JAL, 5'd7), 32'h40, 1'b1, 5'd31);
        commit(mk(OP_SETX, 5'd2), 32'h50, 1'b1, 5'd30);
        commit(mk(OP_ALU, 5'd0), 32'h60, 1'b0, 5'd0);
        commit(mk(OP_BR, 5'd9), 32'h70, 1'b0, 5'd0);
        commit(32'h0, 32'h0, 1'b0, 5'd0);
        commit(mk(OP_LW, 5'd12), 32'h80, 1'b1, 5'd12);
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "dec_idle");
        cnt_chk("dec_cnt");

        // Stalls: not ready, halted, empty-with-ready.
        head(1'b0, mk(OP_ALU, 5'd9), 32'h90, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, "nrdy");
        head(1'b0, mk(OP_ALU, 5'd9), 32'h90, 1'b1);
        halt = 1'b1;
        cyc(1'b0, 1'b0, "halt");
        halt = 1'b0;
        head(1'b1, mk(OP_ALU, 5'd9), 32'h90, 1'b1);
        cyc(1'b0, 1'b0, "empty");
        commit(mk(OP_ALU, 5'd9), 32'h90, 1'b1, 5'd9);

        // Halt raised while waiting does not stop the store; ack on unready head does not pop.
        head(1'b0, sw, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, "st2_req");
        halt = 1'b1;
        cyc(1'b0, 1'b1, "st2_w");
        st_ack = 1'b1;
        head_ready = 1'b0;
        cyc(1'b0, 1'b1, "st2_nrdy_ack");
        head_ready = 1'b1;
        cyc(1'b1, 1'b1, "st2_ack");
        st_ack = 1'b0;
        head(1'b0, mk(OP_ALU, 5'd9), 32'h91, 1'b1);
        cyc(1'b0, 1'b0, "st2_halt_idle");
        halt = 1'b0;
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "st2_idle");
        cnt_chk("st2_cnt");

        // Reset mid-store abandons it at once.
        head(1'b0, sw, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, "st3_req");
        cyc(1'b0, 1'b1, "st3_w");
        st_ack = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_stc", st_commit, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pop", rob_pop, 0);
        chk("rst_mid_cnt", retire_count, 0);
        exp_ret = 0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        st_ack = 1'b0;
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "rst_idle");
        cnt_chk("rst_mid_cnt2");

        // Wrap of the 3-bit counter after 8 commits, then one more.
        for (int i = 0; i < 8; i++) commit(mk(OP_ALU, 5'd1), 32'h100 + i, 1'b1, 5'd1);
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "wrap_idle");
        cnt_chk("wrap8");
        chk("wrap8_zero", retire_count3, 0);
        commit(mk(OP_ALU, 5'd2), 32'h200, 1'b1, 5'd2);
        head(1'b1, 32'h0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, "wrap9_idle");
        cnt_chk("wrap9");

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
